// File: rtl/rs_ff_relay_fifo.sv
// Receive-side FIFO for a feed-forward channel with an early almost-full credit.
// Latency: written word visible on if_dout one cycle after the write edge.
// Backpressure: if_full_n drops GRACE words early; writes into a full FIFO are dropped and flagged.
module rs_ff_relay_fifo #(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 16,
   parameter int PIPELINE_LEVEL = 2,
   parameter     __REGION       = ""
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DATA_WIDTH-1:0]        if_din,
   input  logic                         if_write,
   output logic                         if_full_n,
   output logic [DATA_WIDTH-1:0]        if_dout,
   output logic                         if_empty_n,
   input  logic                         if_read,
   output logic [$clog2(DEPTH+1)-1:0]   if_count,
   output logic                         if_overflow
);

   localparam int GRACE       = 2 * PIPELINE_LEVEL + 1;
   localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW          = $clog2(DEPTH + 1);
   localparam int REGION_BITS = $bits(__REGION);

   // The region tag only steers floorplanning; it is referenced here so it is not dangling.
   if (DEPTH <= GRACE || REGION_BITS < 0) begin : g_bad_depth
      $error("rs_ff_relay_fifo: DEPTH must exceed 2*PIPELINE_LEVEL+1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wp;
   logic [AW-1:0]         rp;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic                  rd_acc;
   logic                  wr_acc;

   // A pop frees a slot in the same cycle, so a full FIFO can still take a write alongside a read.
   assign rd_acc   = if_read && (cnt != '0);
   assign wr_acc   = if_write && ((cnt != CW'(DEPTH)) || rd_acc);
   assign cnt_next = cnt + CW'(wr_acc) - CW'(rd_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp          <= '0;
         rp          <= '0;
         cnt         <= '0;
         if_full_n   <= 1'b0;
         if_overflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
         end
         if (rd_acc) begin
            rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
         end
         if (if_write && !wr_acc) begin
            if_overflow <= 1'b1;
         end
         cnt       <= cnt_next;
         if_full_n <= (cnt_next < CW'(DEPTH - GRACE));
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wp] <= if_din;
      end
   end

   assign if_dout    = mem[rp];
   assign if_empty_n = (cnt != '0);
   assign if_count   = cnt;

endmodule

// File: doc/rs_ff_relay_fifo.md
# rs_ff_relay_fifo

Receiving-end buffer for a feed-forward (no-backpressure) inter-slot channel. Upstream data/valid travel through a fixed number of pass-through-or-register stages, so the producer learns about backpressure late; this block absorbs the in-flight words in a FIFO and drives an early almost-full credit (`if_full_n`) back through the same register chain. It sits directly downstream of the last feed-forward register stage and feeds the consuming slot with a standard FIFO read interface.

## Interface
- `DATA_WIDTH`, 32, payload width.
- `DEPTH`, 16, storage words; must satisfy DEPTH > GRACE, where GRACE = 2*PIPELINE_LEVEL + 1.
- `PIPELINE_LEVEL`, 2, feed-forward register stages per direction between producer and this block (0 = direct).
- `__REGION`, "", floorplan region tag; no functional effect.

- `clk` in 1, the single clock; all state on its rising edge.
- `rst_n` in 1, reset, asynchronous, active-low.
- `if_din` in DATA_WIDTH, write data, qualified by `if_write`.
- `if_write` in 1, write strobe arriving through the feed-forward chain; no handshake.
- `if_full_n` out 1, credit to producer: 1 = producer may issue writes.
- `if_dout` out DATA_WIDTH, head-of-queue word (show-ahead), valid when `if_empty_n`=1.
- `if_empty_n` out 1, 1 = at least one word stored.
- `if_read` in 1, pop strobe from consumer.
- `if_count` out $clog2(DEPTH+1), current occupancy.
- `if_overflow` out 1, sticky: a write was dropped.

## Operation
- Storage: DEPTH-entry memory, write pointer `wp`, read pointer `rp`, both wrap from DEPTH-1 to 0 (DEPTH need not be a power of two), occupancy counter `cnt` in 0..DEPTH.
- Write accept: `if_write` && (cnt < DEPTH || read accepted same cycle). Accepted write stores `if_din` at `wp`, advances `wp`.
- Write with cnt == DEPTH and no accepted read: word dropped, pointers/cnt unchanged, `if_overflow` set to 1 and held until reset.
- Read accept: `if_read` && cnt > 0. Advances `rp`. Read with cnt == 0 ignored (no bypass even if a write arrives the same cycle).
- cnt_next = cnt + write_acc - read_acc.
- `if_empty_n` = (cnt != 0); `if_count` = cnt; `if_dout` = mem[rp] combinationally (undefined content when empty, must not be X-propagated into control).
- `if_full_n` registered: next value = (cnt_next < DEPTH - GRACE). GRACE covers PIPELINE_LEVEL cycles for credit to reach producer, PIPELINE_LEVEL cycles for in-flight writes, plus one for this register; a compliant producer therefore never causes overflow.
- No state machine beyond pointers/counter/flags; `__REGION` ignored.

## Timing
- Reset (rst_n=0, immediate, no clock needed): wp=rp=cnt=0, `if_empty_n`=0, `if_count`=0, `if_overflow`=0, `if_full_n`=0. Memory contents not reset.
- First rising edge after rst_n release: `if_full_n` goes 1.
- Write at edge N: `if_empty_n`=1, `if_count` incremented, `if_dout` shows word after edge N (latency 1).
- Read at edge N: next word (or empty) visible after edge N.
- `if_full_n` falls the edge at which cnt_next reaches DEPTH-GRACE; rises the edge cnt_next drops below it.
- Simultaneous read+write at cnt == DEPTH: both accepted, cnt stays DEPTH, no overflow.
- Simultaneous read+write at 0 < cnt < DEPTH: cnt unchanged, FIFO order preserved across pointer wrap.
- Reset asserted mid-stream: all stored words discarded instantly; outputs return to reset values asynchronously.

## Test plan
- Reset/credit: hold rst_n=0 -> `if_full_n`=0, `if_empty_n`=0, `if_overflow`=0; release -> `if_full_n`=1 after first edge.
- Credit threshold (defaults, GRACE=5): write 0x1..0xB one per cycle, no reads -> `if_full_n` falls on the edge cnt reaches 11; continue writing 5 grace words 0xC..0x10 -> cnt=16, `if_overflow`=0.
- Overflow: at cnt=16 write 0xDEAD without read -> dropped, cnt=16, `if_overflow`=1 sticky; drain 16 reads -> data 0x1..0x10 in order, `if_empty_n`=0.
- Full concurrent: at cnt=16 write 0x55 and read same cycle -> `if_dout` was 0x1, cnt stays 16, no overflow, 0x55 emerges last.
- Wrap-around: 40 cycles random write/read with cnt kept 1..8 -> scoreboard matches, pointers wrap ≥2 times; read on empty with simultaneous write -> cnt=1, read ignored.
- Reset mid-operation: cnt=7, drop rst_n between edges -> `if_empty_n`=0, `if_count`=0 immediately; after release, write 0xA5 -> `if_dout`=0xA5.
